// File: rtl/rsa_pkg.sv
// Shared defaults and sequencer state encoding for the modular exponentiation block.
package rsa_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int EXP_WIDTH_DEF = 32;
  localparam int LEN_W_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TO_MONT,
    ST_INIT_ACC,
    ST_SCAN,
    ST_SQUARE,
    ST_MULT,
    ST_FROM_MONT,
    ST_DONE
  } step_t;

  // Every multiplier step is split into an issue cycle and a wait phase.
  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_WAIT  = 1'b1
  } phase_t;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a single Montgomery multiplier.
//
// state        | meaning
// IDLE         | waiting for start
// TO_MONT      | mbase = MM(base, R^2 mod N)
// INIT_ACC     | acc = MM(1, R^2 mod N) = R mod N
// SCAN         | walk down from the top exponent bit to the highest set bit
// SQUARE       | acc = MM(acc, acc)
// MULT         | acc = MM(acc, mbase) for a set exponent bit
// FROM_MONT    | result = MM(acc, 1)
// DONE         | one-cycle done pulse, then back to IDLE
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int EXP_WIDTH = EXP_WIDTH_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [WIDTH-1:0]     r2_mod,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_n,
  output logic [LEN_W-1:0]     mm_len,
  input  logic                 mm_done,
  input  logic [WIDTH-1:0]     mm_result
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  step_t                step_q, step_d;
  phase_t               phase_q, phase_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     mod_q, mod_d;
  logic [WIDTH-1:0]     r2_q, r2_d;
  logic [WIDTH-1:0]     mbase_q, mbase_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 param_bad;
  logic                 mm_step;

  assign param_bad = ~modulus[0] || (len == '0) || (32'(len) > 32'(WIDTH));
  assign mm_step   = (step_q == ST_TO_MONT) || (step_q == ST_INIT_ACC) || (step_q == ST_SQUARE)
                  || (step_q == ST_MULT) || (step_q == ST_FROM_MONT);

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= ST_IDLE;
      phase_q  <= PH_ISSUE;
      len_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      r2_q     <= '0;
      mbase_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      step_q   <= step_d;
      phase_q  <= phase_d;
      len_q    <= len_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      r2_q     <= r2_d;
      mbase_q  <= mbase_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    phase_d  = phase_q;
    len_d    = len_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    r2_d     = r2_q;
    mbase_d  = mbase_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    err_d    = err_q;

    case (step_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = len;
          base_d   = base;
          exp_d    = exponent;
          mod_d    = modulus;
          r2_d     = r2_mod;
          err_d    = param_bad;
          result_d = '0;
          phase_d  = PH_ISSUE;
          step_d   = param_bad ? ST_DONE : ST_TO_MONT;
        end
      end
      ST_SCAN: begin
        if (exp_q == '0) begin
          step_d = ST_FROM_MONT;
        end else if (exp_q[idx_q]) begin
          step_d = ST_SQUARE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: step_d = ST_IDLE;
      default: begin
        if (phase_q == PH_ISSUE) begin
          phase_d = PH_WAIT;
        end else if (mm_done) begin
          phase_d = PH_ISSUE;
          case (step_q)
            ST_TO_MONT: begin
              mbase_d = mm_result;
              step_d  = ST_INIT_ACC;
            end
            ST_INIT_ACC: begin
              acc_d  = mm_result;
              idx_d  = IDX_W'(EXP_WIDTH - 1);
              step_d = ST_SCAN;
            end
            ST_SQUARE, ST_MULT: begin
              acc_d = mm_result;
              // A set bit gets its multiply before moving to the next lower bit.
              if ((step_q == ST_SQUARE) && exp_q[idx_q]) begin
                step_d = ST_MULT;
              end else if (idx_q == '0) begin
                step_d = ST_FROM_MONT;
              end else begin
                idx_d  = idx_q - 1'b1;
                step_d = ST_SQUARE;
              end
            end
            ST_FROM_MONT: begin
              result_d = mm_result;
              step_d   = ST_DONE;
            end
            default: step_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (step_q)
      ST_TO_MONT:   begin mm_a = base_q; mm_b = r2_q;    end
      ST_INIT_ACC:  begin mm_a = ONE;    mm_b = r2_q;    end
      ST_SQUARE:    begin mm_a = acc_q;  mm_b = acc_q;   end
      ST_MULT:      begin mm_a = acc_q;  mm_b = mbase_q; end
      ST_FROM_MONT: begin mm_a = acc_q;  mm_b = ONE;     end
      default:      begin mm_a = '0;     mm_b = '0;      end
    endcase
  end

  assign mm_start = mm_step && (phase_q == PH_ISSUE);
  assign mm_n     = mod_q;
  assign mm_len   = len_q;
  assign busy     = (step_q != ST_IDLE) && (step_q != ST_DONE);
  assign done     = (step_q == ST_DONE);
  assign err      = err_q;
  assign result   = result_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural Montgomery multiplier of configurable latency.
module tb_mod_exp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [31:0] base = '0;
  logic [31:0] exponent = '0;
  logic [31:0] modulus = '0;
  logic [31:0] r2_mod = '0;
  logic        busy, done, err, mm_start;
  logic [31:0] result, mm_a, mm_b, mm_n;
  logic [7:0]  mm_len;
  logic        mm_done = 1'b0;
  logic [31:0] mm_result = '0;

  mod_exp_ctrl #(.WIDTH(32), .EXP_WIDTH(32), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .base(base), .exponent(exponent),
    .modulus(modulus), .r2_mod(r2_mod), .busy(busy), .done(done), .err(err), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n), .mm_len(mm_len),
    .mm_done(mm_done), .mm_result(mm_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: a*b*2^-len mod n, returned after mm_lat+1 cycles.
  function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] n, input logic [7:0] l);
    logic [95:0] t;
    t = 96'(a) * 96'(b);
    for (int i = 0; i < int'(l); i++) begin
      if (t[0]) t = t + 96'(n);
      t = t >> 1;
    end
    if (t >= 96'(n)) t = t - 96'(n);
    return t[31:0];
  endfunction

  int          mm_lat = 1;
  int          mm_cnt = 0;
  bit          mm_busy = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, op_n = '0;
  logic [7:0]  op_len = '0;
  int          mm_pulses = 0;

  always @(posedge clk) begin
    mm_done <= 1'b0;
    if (mm_busy) begin
      if (mm_cnt == 0) begin
        mm_done   <= 1'b1;
        mm_result <= mont(op_a, op_b, op_n, op_len);
        mm_busy   <= 1'b0;
      end else begin
        mm_cnt <= mm_cnt - 1;
      end
    end
    if (mm_start) begin
      mm_busy   <= 1'b1;
      mm_cnt    <= mm_lat;
      op_a      <= mm_a;
      op_b      <= mm_b;
      op_n      <= mm_n;
      op_len    <= mm_len;
      mm_pulses <= mm_pulses + 1;
    end
  end

  typedef struct {
    logic [7:0]  len;
    logic [31:0] base;
    logic [31:0] expo;
    logic [31:0] modn;
    logic [31:0] r2;
    logic        err;
    logic [31:0] res;
    int          pulses;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input string tag, input vec_t v, input bit disturb, input bit poke_done);
    int  p0;
    int  cyc;
    bit  seen_done;
    bit  busy_gap;
    mm_lat = v.lat;
    @(negedge clk);
    len = v.len; base = v.base; exponent = v.expo; modulus = v.modn; r2_mod = v.r2;
    start = 1'b1;
    p0 = mm_pulses;
    @(negedge clk);
    start = 1'b0;
    if (disturb) base = 32'd5;
    seen_done = 1'b0;
    busy_gap = 1'b0;
    cyc = 0;
    while (!seen_done && cyc < 3000) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (!busy) busy_gap = 1'b1;
        if (disturb) start = ((cyc % 7) == 3);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(seen_done), 64'd1);
    if (seen_done) begin
      check({tag, " err"}, 64'(err), 64'(v.err));
      check({tag, " result"}, 64'(result), 64'(v.res));
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check({tag, " mm_pulses"}, 64'(mm_pulses - p0), 64'(v.pulses));
      check({tag, " busy_continuous"}, 64'(busy_gap), 64'd0);
      if (poke_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " done_one_cycle"}, 64'(done), 64'd0);
      check({tag, " idle_after_done"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int  p0;
    int  cyc;
    bit  bad;

    //          len    base           exp            modulus        r2             err   result  pulses lat
    vecs[0]  = '{8'd4,  32'd3,  32'd5,         32'd13,        32'd9,   1'b0, 32'd9,  8,  2};
    vecs[1]  = '{8'd10, 32'd2,  32'd10,        32'd1009,      32'd225, 1'b0, 32'd15, 9,  0};
    vecs[2]  = '{8'd4,  32'd7,  32'd0,         32'd13,        32'd9,   1'b0, 32'd1,  3,  1};
    vecs[3]  = '{8'd4,  32'd3,  32'd5,         32'd12,        32'd9,   1'b1, 32'd0,  0,  1};
    vecs[4]  = '{8'd0,  32'd3,  32'd5,         32'd13,        32'd9,   1'b1, 32'd0,  0,  1};
    vecs[5]  = '{8'd33, 32'd3,  32'd5,         32'd13,        32'd9,   1'b1, 32'd0,  0,  1};
    vecs[6]  = '{8'd32, 32'd2,  32'd3,         32'hFFFF_FFFB, 32'd25,  1'b0, 32'd8,  7,  4};
    vecs[7]  = '{8'd4,  32'd5,  32'd1,         32'd13,        32'd9,   1'b0, 32'd5,  5,  1};
    vecs[8]  = '{8'd4,  32'd12, 32'd2,         32'd13,        32'd9,   1'b0, 32'd1,  6,  3};
    vecs[9]  = '{8'd4,  32'd0,  32'd7,         32'd13,        32'd9,   1'b0, 32'd0,  9,  0};
    vecs[10] = '{8'd4,  32'd3,  32'h8000_0000, 32'd13,        32'd9,   1'b0, 32'd9,  36, 1};
    vecs[11] = '{8'd4,  32'd2,  32'hFFFF_FFFF, 32'd13,        32'd9,   1'b0, 32'd8,  67, 0};

    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst mm_start", 64'(mm_start), 64'd0);
    check("rst mm_a", 64'(mm_a), 64'd0);
    check("rst mm_b", 64'(mm_b), 64'd0);
    check("rst mm_n", 64'(mm_n), 64'd0);
    check("rst mm_len", 64'(mm_len), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);
    end

    run_vec("disturbed", vecs[0], 1'b1, 1'b0);
    run_vec("start_in_done", vecs[2], 1'b0, 1'b1);
    run_vec("after_done_start", vecs[7], 1'b0, 1'b0);

    // Reset while waiting on the first square; the in-flight multiply completes afterwards.
    mm_lat = 3;
    @(negedge clk);
    len = 8'd4; base = 32'd3; exponent = 32'd5; modulus = 32'd13; r2_mod = 32'd9;
    start = 1'b1;
    p0 = mm_pulses;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((mm_pulses - p0) < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid reached_square", 64'(mm_pulses - p0), 64'd3);
    check("rst_mid busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid done", 64'(done), 64'd0);
    check("rst_mid err", 64'(err), 64'd0);
    check("rst_mid result", 64'(result), 64'd0);
    check("rst_mid mm_start", 64'(mm_start), 64'd0);
    check("rst_mid mm_a", 64'(mm_a), 64'd0);
    check("rst_mid mm_b", 64'(mm_b), 64'd0);
    check("rst_mid mm_n", 64'(mm_n), 64'd0);
    check("rst_mid mm_len", 64'(mm_len), 64'd0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || mm_start) bad = 1'b1;
    end
    check("rst_mid quiet_after", 64'(bad), 64'd0);
    run_vec("after_rst", vecs[0], 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
Sequencer that computes base^exponent mod modulus by driving one external Montgomery multiplier (mont_mult) through a left-to-right square-and-multiply schedule. It handles conversion into the Montgomery domain (×R² mod N), the exponent scan, and conversion back out (×1). It sits between the RSA top-level register interface and the mont_mult datapath, and is the only requester of that multiplier.

Parameters:
WIDTH, 32, operand/modulus width in bits (matches mont_mult operands)
EXP_WIDTH, 32, exponent width in bits
LEN_W, 8, width of the bit-length field passed to mont_mult

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
len  in  LEN_W  modulus bit length; R = 2^len
base  in  WIDTH  message/base, required < modulus
exponent  in  EXP_WIDTH  exponent
modulus  in  WIDTH  odd modulus N
r2_mod  in  WIDTH  precomputed R² mod N
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when result/err valid
err  out  1  valid with done; parameter error
result  out  WIDTH  base^exponent mod N, held until next accepted start
mm_start  out  1  one-cycle pulse to mont_mult
mm_a  out  WIDTH  mont_mult operand 1
mm_b  out  WIDTH  mont_mult operand 2
mm_n  out  WIDTH  modulus to mont_mult
mm_len  out  LEN_W  length to mont_mult
mm_done  in  1  mont_mult completion (module_end)
mm_result  in  WIDTH  mont_mult output

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: busy=0, done=0, err=0, result=0, mm_start=0, mm_a=0, mm_b=0, mm_n=0, mm_len=0. State is IDLE.
- Reset asserted mid-operation: controller returns to IDLE on the next edge and no done is issued. A mont_mult operation already in flight is abandoned; later mm_done is ignored.
- On accepted start, latch len, base, exponent, modulus, and r2_mod. Inputs may change afterwards without effect.
- Parameter check at accept:
  - Error conditions: modulus[0]==0, len==0, or len>WIDTH.
  - On error: go to DONE next cycle with err=1 and result=0. No mm_start is issued.
- MM operation protocol:
  - ISSUE cycle: drive mm_a, mm_b, mm_n, mm_len and pulse mm_start for exactly 1 cycle. Operands stay stable until mm_done.
  - WAIT: ignore mm_done during the ISSUE cycle. The first mm_done seen in WAIT captures mm_result into the target register.
- States, each MM state being an ISSUE/WAIT pair:
  - IDLE: wait for start.
  - TO_MONT: mbase = MM(base, r2_mod).
  - INIT_ACC: acc = MM(1, r2_mod) = R mod N.
  - SCAN: bit index i = highest set bit of exponent. The search uses a 1-bit-per-cycle down-count from EXP_WIDTH-1, max EXP_WIDTH cycles. If exponent==0, go straight to FROM_MONT.
  - SQUARE: acc = MM(acc, acc).
  - MULT: acc = MM(acc, mbase); entered only if exponent[i]==1.
  - After SQUARE (bit i clear) or after MULT: if i==0 go to FROM_MONT, else i-1 and go to SQUARE.
  - FROM_MONT: result = MM(acc, 1).
  - DONE: done=1 for one cycle, busy falls in the same cycle, then IDLE.
- MM count = 3 + (msb_index+1) + popcount(exponent); exponent==0 gives 3 ops.
- start while busy: ignored, with no effect on the run in progress.
- start in the DONE cycle: ignored; accepted from IDLE next cycle.
- mm_n and mm_len hold the latched values for the whole run.

Decomposition:
- Shared package (rsa_pkg): WIDTH/EXP_WIDTH/LEN_W defaults and the state encoding constants (IDLE, TO_MONT, INIT_ACC, SCAN, SQUARE, MULT, FROM_MONT, DONE, plus the ISSUE/WAIT phase bit).
- No internal sub-module. A wrapper mod_exp_top instantiates mod_exp_ctrl plus one mont_mult.
- The bench uses mod_exp_top, or a behavioural MM model with configurable latency.

Test Plan:
- len=4, N=13, r2_mod=9, base=3, exp=5 -> done, err=0, result=9. Exactly 8 mm_start pulses.
- len=10, N=1009, r2_mod=225, base=2, exp=10 -> result=15. 9 mm_start pulses.
- exp=0, N=13, len=4, r2_mod=9, base=7 -> result=1. 3 mm_start pulses.
- N=12 (even), then separately len=0 -> err=1 with done, result=0, zero mm_start pulses.
- Extra start pulses mid-run, and base input changed after accept, in the 3^5 mod 13 run -> result still 9, pulse count still 8, busy continuous.
- rst asserted during SQUARE of a run -> all outputs at reset values next cycle, no done. A fresh 3^5 mod 13 run afterwards -> 9.
